// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding,
// slot-count and width helpers, and the minimum slot length.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_CLR_GAP = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // A PE controller needs two cycles between pulses to get back to idle.
    localparam int MIN_SLOT = 2;

    function automatic int num_slots(input int n, input int k);
        return k + 2 * n - 2;
    endfunction

    // Bits needed to hold 0..x-1, never less than one.
    function automatic int clog2_min1(input int x);
        int r;
        r = 0;
        while ((1 << r) < x) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit slot_ok(input int slot);
        return slot >= MIN_SLOT;
    endfunction

endpackage

// File: rtl/sa_slot_timer.sv
// Nested cycle/slot counters for the RUN phase: the cycle counter spans one
// wavefront slot, the slot counter saturates at the last slot.
module sa_slot_timer
    import sa_ctrl_pkg::*;
#(
    parameter int SLOT = 4,
    parameter int S    = 10,
    localparam int CW  = clog2_min1(SLOT),
    localparam int SW  = clog2_min1(S)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic          slot_tick,
    output logic          last_slot,
    output logic [SW-1:0] slot_idx
);

    localparam logic [CW-1:0] C_LAST = CW'(SLOT - 1);
    localparam logic [SW-1:0] S_LAST = SW'(S - 1);

    logic [CW-1:0] cyc_r;
    logic [SW-1:0] slot_r;

    // Advance the cycle counter every enabled cycle, the slot counter on wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_r  <= '0;
            slot_r <= '0;
        end else if (clear) begin
            cyc_r  <= '0;
            slot_r <= '0;
        end else if (enable) begin
            if (cyc_r == C_LAST) begin
                cyc_r <= '0;
                if (slot_r != S_LAST) begin
                    slot_r <= slot_r + SW'(1);
                end
            end else begin
                cyc_r <= cyc_r + CW'(1);
            end
        end
    end

    assign slot_tick = (cyc_r == '0);
    assign last_slot = (cyc_r == C_LAST) && (slot_r == S_LAST);
    assign slot_idx  = slot_r;

endmodule

// File: rtl/systolic_array_sequencer.sv
// Array-level sequencer: one broadcast clear, then K diagonal start
// wavefronts with feeder strobes, a drain period and a done pulse.
module systolic_array_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int N         = 4,
    parameter int K         = 4,
    parameter int SLOT      = 4,
    parameter int DRAIN_CYC = 8,
    localparam int ND       = 2 * N - 1,
    localparam int FW       = clog2_min1(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          pe_clr,
    output logic [ND-1:0] pe_start,
    output logic          feed_en,
    output logic [FW-1:0] feed_idx
);

    localparam int S  = num_slots(N, K);
    localparam int SW = clog2_min1(S);
    localparam int DW = clog2_min1(DRAIN_CYC);
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [31:0]   K_U    = 32'(K);

    if (!slot_ok(SLOT)) begin : g_slot_check
        $error("SLOT must be at least 2");
    end

    state_t        state_r;
    state_t        state_s;
    logic [DW-1:0] drain_r;
    logic          slot_tick_s;
    logic          last_slot_s;
    logic [SW-1:0] slot_idx_s;
    logic [31:0]   s_ext_s;
    logic          kill_s;
    logic          busy_s;
    logic          done_s;
    logic          clr_s;
    logic          fen_s;
    logic [ND-1:0] start_s;
    logic [FW-1:0] fidx_s;

    sa_slot_timer #(
        .SLOT (SLOT),
        .S    (S)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_r != ST_RUN),
        .enable    (state_r == ST_RUN),
        .slot_tick (slot_tick_s),
        .last_slot (last_slot_s),
        .slot_idx  (slot_idx_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_s = go ? ST_CLEAR : ST_IDLE;
                ST_CLEAR:   state_s = ST_CLR_GAP;
                ST_CLR_GAP: state_s = ST_RUN;
                ST_RUN:     state_s = last_slot_s ? ST_DRAIN : ST_RUN;
                ST_DRAIN:   state_s = (drain_r == D_LAST) ? ST_DONE : ST_DRAIN;
                ST_DONE:    state_s = ST_IDLE;
                default:    state_s = ST_IDLE;
            endcase
        end
    end

    // Drain counter, held at zero outside DRAIN so it restarts on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_r <= '0;
        end else if (state_r != ST_DRAIN) begin
            drain_r <= '0;
        end else if (drain_r != D_LAST) begin
            drain_r <= drain_r + DW'(1);
        end
    end

    // Output decode of the current state; the registers below delay it one
    // cycle, so pulses appear the cycle after the state/counter that causes them.
    always_comb begin
        s_ext_s = 32'(slot_idx_s);
        kill_s  = abort && (state_r != ST_IDLE);
        busy_s  = 1'b0;
        done_s  = 1'b0;
        clr_s   = 1'b0;
        fen_s   = 1'b0;
        start_s = '0;
        fidx_s  = feed_idx;
        if (kill_s) begin
            fidx_s = '0;
        end else begin
            busy_s = (state_r != ST_IDLE);
            done_s = (state_r == ST_DONE);
            clr_s  = (state_r == ST_CLEAR);
            if ((state_r == ST_RUN) && slot_tick_s) begin
                for (int d = 0; d < ND; d++) begin
                    start_s[d] = (s_ext_s >= unsigned'(d)) &&
                                 ((s_ext_s - unsigned'(d)) < K_U);
                end
                if (s_ext_s < K_U) begin
                    fen_s  = 1'b1;
                    fidx_s = slot_idx_s[FW-1:0];
                end else begin
                    fen_s  = 1'b0;
                end
            end else begin
                start_s = '0;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            pe_clr   <= 1'b0;
            pe_start <= '0;
            feed_en  <= 1'b0;
            feed_idx <= '0;
        end else begin
            busy     <= busy_s;
            done     <= done_s;
            pe_clr   <= clr_s;
            pe_start <= start_s;
            feed_en  <= fen_s;
            feed_idx <= fidx_s;
        end
    end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer: default config plus the
// N=1/K=1/SLOT=2/DRAIN_CYC=1 corner, with a pulse-protocol monitor.
module tb_systolic_array_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       abort;
    logic       go_c;
    logic       busy, done, pe_clr, feed_en;
    logic [6:0] pe_start;
    logic [1:0] feed_idx;
    logic       busy_c, done_c, pe_clr_c, feed_en_c;
    logic [0:0] pe_start_c;
    logic [0:0] feed_idx_c;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int last_hi   [7] = '{default: -100};
    int pulse_cnt [7] = '{default: 0};
    int ov_cnt  = 0;
    int gap_cnt = 0;
    int snap_cnt [7];
    int snap_ov;
    int snap_gap;

    systolic_array_sequencer #(.N(4), .K(4), .SLOT(4), .DRAIN_CYC(8)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .busy(busy), .done(done), .pe_clr(pe_clr), .pe_start(pe_start),
        .feed_en(feed_en), .feed_idx(feed_idx)
    );

    systolic_array_sequencer #(.N(1), .K(1), .SLOT(2), .DRAIN_CYC(1)) dut_c (
        .clk(clk), .rst(rst), .go(go_c), .abort(1'b0),
        .busy(busy_c), .done(done_c), .pe_clr(pe_clr_c), .pe_start(pe_start_c),
        .feed_en(feed_en_c), .feed_idx(feed_idx_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Protocol monitor: clr/start overlap, per-bit spacing and pulse counts.
    always @(negedge clk) begin
        if (pe_clr && (|pe_start)) ov_cnt <= ov_cnt + 1;
        for (int d = 0; d < 7; d++) begin
            if (pe_start[d]) begin
                if (cyc - last_hi[d] < 4) gap_cnt <= gap_cnt + 1;
                last_hi[d]   <= cyc;
                pulse_cnt[d] <= pulse_cnt[d] + 1;
            end
        end
    end

    function automatic logic [12:0] obs_main();
        return {busy, done, pe_clr, pe_start, feed_en, feed_idx};
    endfunction

    // Expected default-config outputs 'rel' cycles after the go edge.
    function automatic logic [12:0] exp_out(input int rel, input logic [1:0] prev);
        logic       b, dn, cl, fe;
        logic [6:0] st;
        logic [1:0] fi;
        int         r, s;
        b  = (rel >= 1) && (rel <= 51);
        dn = (rel == 51);
        cl = (rel == 1);
        st = '0;
        fe = 1'b0;
        fi = prev;
        r  = rel - 3;
        if (r >= 0 && r < 40 && (r % 4) == 0) begin
            s = r / 4;
            for (int d = 0; d < 7; d++) st[d] = (s >= d) && (s - d < 4);
            fe = (s < 4);
        end
        if (r >= 0) fi = (r / 4 >= 3) ? 2'd3 : 2'(r / 4);
        return {b, dn, cl, st, fe, fi};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_window(input int t0, input int r_from, input int r_to,
                                input logic [1:0] prev, input string tag);
        for (int rel = r_from; rel <= r_to; rel++) begin
            while (cyc < t0 + rel) @(negedge clk);
            chk($sformatf("%s@%0d", tag, t0 + rel), 64'(obs_main()), 64'(exp_out(rel, prev)));
        end
    endtask

    task automatic snapshot();
        for (int d = 0; d < 7; d++) snap_cnt[d] = pulse_cnt[d];
        snap_ov  = ov_cnt;
        snap_gap = gap_cnt;
    endtask

    task automatic check_protocol(input int per_bit, input string tag);
        chk({tag, "_overlap"}, 64'(ov_cnt - snap_ov), 64'd0);
        chk({tag, "_gap"}, 64'(gap_cnt - snap_gap), 64'd0);
        for (int d = 0; d < 7; d++)
            chk($sformatf("%s_pulses[%0d]", tag, d), 64'(pulse_cnt[d] - snap_cnt[d]), 64'(per_bit));
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b0;
        go    = 1'b0;
        abort = 1'b0;
        go_c  = 1'b0;
        #2;
        chk("reset_main", 64'(obs_main()), 64'd0);
        chk("reset_corner", 64'({busy_c, done_c, pe_clr_c, pe_start_c, feed_en_c, feed_idx_c}), 64'd0);
        #1 rst = 1'b1;
        @(negedge clk);

        // Basic run, go sampled at edge 10.
        wait_cyc(9);
        snapshot();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_window(10, 0, 60, 2'd0, "basic");
        chk("basic_clr_11", 64'(pe_clr), 64'd0);
        check_protocol(4, "basic");

        // Abort mid-run: abort high during cycle 100 (rel 20).
        wait_cyc(79);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_window(80, 0, 20, 2'd3, "pre_abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 64'(obs_main()), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("post_abort@%0d", cyc), 64'(obs_main()), 64'd0);
        end
        wait_cyc(149);
        snapshot();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_window(150, 0, 60, 2'd0, "rerun");
        check_protocol(4, "rerun");

        // Async reset between edges during RUN.
        wait_cyc(219);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_window(220, 0, 10, 2'd3, "pre_rst");
        #1 rst = 1'b0;
        #1 chk("async_rst", 64'(obs_main()), 64'd0);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst@%0d", cyc), 64'(obs_main()), 64'd0);
        end

        // go held high: two identical back-to-back runs.
        wait_cyc(249);
        snapshot();
        go = 1'b1;
        check_window(250, 0, 51, 2'd0, "hold1");
        check_window(302, 0, 51, 2'd3, "hold2");
        go = 1'b0;
        check_window(302, 52, 56, 2'd3, "hold_end");
        check_protocol(8, "hold");

        // Corner configuration, go sampled at edge 370.
        wait_cyc(369);
        go_c = 1'b1;
        @(negedge clk);
        go_c = 1'b0;
        for (int rel = 0; rel <= 9; rel++) begin
            wait_cyc(370 + rel);
            chk($sformatf("corner@%0d", rel),
                64'({busy_c, done_c, pe_clr_c, pe_start_c, feed_en_c, feed_idx_c}),
                64'({(rel >= 1) && (rel <= 6), rel == 6, rel == 1, rel == 3, rel == 3, 1'b0}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
